assoc_dcache: RTL
=================

ASSOC_DCACHE -- requirements
Module: assoc_dcache

Interface
REQ-001 SHALL have parameters, one per line:
  ADDR_W, 32, address width in bits
  DATA_W, 32, data word width in bits
  WAYS, 2, associativity (power of two, >=1)
  SETS, 64, sets per way (power of two, >=2)
  LINE_WORDS, 4, words per line (power of two, >=1)
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  cpu_req  in  1  access request
  cpu_we  in  1  1 = write, 0 = read
  cpu_addr  in  ADDR_W  byte address, word aligned
  cpu_wdata  in  DATA_W  write data
  cpu_rdata  out  DATA_W  read data, valid when cpu_ready is 1
  cpu_ready  out  1  access completes this cycle
  cpu_stall  out  1  cpu_req & ~cpu_ready
  mem_req  out  1  line transfer request
  mem_we  out  1  1 = line writeback, 0 = line refill
  mem_addr  out  ADDR_W  line-aligned address
  mem_wline  out  DATA_W*LINE_WORDS  writeback line, word 0 in LSBs
  mem_rline  in  DATA_W*LINE_WORDS  refill line, word 0 in LSBs
  mem_ack  in  1  one-cycle transfer-complete pulse
REQ-003 SHALL have one clock, and reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL split cpu_addr as follows: [1:0] byte, then log2(LINE_WORDS) word offset, then log2(SETS) index, with the remainder as tag.
REQ-005 SHALL store per way and set: valid, dirty, tag, and line data.
REQ-006 SHALL use FSM states IDLE, WRITEBACK and REFILL.
REQ-007 In IDLE, a hit SHALL be cpu_req with a valid matching tag in some way; at most one way SHALL ever match.
REQ-008 On a read hit, cpu_ready=1 and cpu_rdata=the addressed word SHALL occur in the same cycle (combinational).
REQ-009 On a write hit, cpu_ready=1 SHALL occur in the same cycle; the word SHALL be updated and dirty set at that edge.
REQ-010 On a miss in IDLE, the next state SHALL be WRITEBACK if the victim is valid and dirty, otherwise REFILL; cpu_ready SHALL be 0.
REQ-011 Victim selection SHALL be the lowest-index invalid way; if all ways are valid, the way given by the per-set round-robin pointer, which then increments modulo WAYS.
REQ-012 In WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wline=victim line; on mem_ack, clear victim dirty and go to REFILL.
REQ-013 In REFILL: mem_req=1, mem_we=0, mem_addr=cpu_addr with the offset bits zeroed; on mem_ack, write mem_rline into the victim, set valid=1, dirty=0, load the tag, and go to IDLE.
REQ-014 After REFILL the held request SHALL re-look up and hit. Miss-to-ready latency is therefore ack cycle + 1 (plus writeback time).
REQ-015 The CPU SHALL hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_stall=1; the block is not required to handle changes.
REQ-016 mem_req, mem_we and mem_addr SHALL be held stable from assertion until mem_ack.
REQ-017 mem_ack in IDLE, or without mem_req, SHALL be ignored.
REQ-018 With cpu_req=0: cpu_ready=0, no state change, and no array write.
REQ-019 The victim way SHALL be latched on the IDLE-exit edge and used for both WRITEBACK and REFILL.

Reset
REQ-020 When rst=0, asynchronously: state=IDLE, all valid=0, all dirty=0, all round-robin pointers=0, mem_req=0, mem_we=0, cpu_ready=0. Tag and data arrays are not reset.
REQ-021 Reset during WRITEBACK or REFILL SHALL abort the transfer, with mem_req dropping immediately; a late mem_ack after release SHALL be ignored.

Verification (WAYS=2, SETS=4, LINE_WORDS=4: index=addr[5:4], tag=addr[31:6])
REQ-022 Cold read of 0x40 -> mem_req=1, mem_we=0, mem_addr=0x40; ack with line {4,3,2,1} -> cpu_ready=1, cpu_rdata=1 one cycle after ack.
REQ-023 Write 0x44 with 0xDEADBEEF (hit) -> cpu_ready the same cycle, no mem_req; read of 0x44 -> 0xDEADBEEF.
REQ-024 Then read 0x80 (fills way1) and read 0xC0 -> WRITEBACK mem_addr=0x40 with mem_wline word1=0xDEADBEEF, then REFILL mem_addr=0xC0; the next miss to set 0 evicts way1.
REQ-025 rst=0 while in REFILL awaiting ack -> mem_req=0 immediately; after release, read of 0x40 misses again.
REQ-026 mem_ack pulsed with cpu_req=0 in IDLE -> no state, valid or output change.

Source files
------------

// File: rtl/assoc_dcache.sv
// Set-associative write-back data cache with one-line refill/writeback memory port.
// Blocking on miss: the CPU request is held while the line is written back and refilled.
module assoc_dcache #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W*LINE_WORDS-1:0] mem_wline,
    input  logic [DATA_W*LINE_WORDS-1:0] mem_rline,
    input  logic                         mem_ack
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WSEL_W  = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned LINE_W  = DATA_W * LINE_WORDS;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0][SETS-1:0]  valid_q;
    logic [WAYS-1:0][SETS-1:0]  dirty_q;
    logic [SETS-1:0][WAY_W-1:0] rr_q;
    logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
    logic [LINE_W-1:0]          data_q [WAYS][SETS];
    logic [WAY_W-1:0]           victim_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic              unused_byte;

    assign idx         = IDX_W'(cpu_addr >> (2 + OFF_W));
    assign tag         = TAG_W'(cpu_addr >> TAG_LSB);
    assign word_sel    = WSEL_W'((cpu_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign unused_byte = ^cpu_addr[1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
    logic             vic_found;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] rr_next;

    always_comb begin
        vic_found = 1'b0;
        vic_way   = rr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[w][idx] && !vic_found) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
    end

    assign rr_next = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

    logic lookup_miss;
    logic write_hit;
    logic wb_done;
    logic refill_done;

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        lookup_miss = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                    end else begin
                        lookup_miss = 1'b1;
                        state_d     = (valid_q[vic_way][idx] && dirty_q[vic_way][idx]) ?
                                      StWriteback : StRefill;
                    end
                end
            end
            StWriteback: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {tag_q[victim_q][idx], idx, {(2 + OFF_W){1'b0}}};
                if (mem_ack) state_d = StRefill;
            end
            StRefill: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[ADDR_W-1:2+OFF_W], {(2 + OFF_W){1'b0}}};
                if (mem_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign write_hit   = cpu_ready & cpu_we;
    assign wb_done     = (state_q == StWriteback) & mem_ack;
    assign refill_done = (state_q == StRefill) & mem_ack;

    assign cpu_rdata = data_q[hit_way][idx][DATA_W*word_sel +: DATA_W];
    assign cpu_stall = cpu_req & ~cpu_ready;
    assign mem_wline = data_q[victim_q][idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            rr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (lookup_miss) begin
                victim_q <= vic_way;
                if (!vic_found) rr_q[idx] <= rr_next;
            end
            if (write_hit) dirty_q[hit_way][idx] <= 1'b1;
            if (wb_done) dirty_q[victim_q][idx] <= 1'b0;
            if (refill_done) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (write_hit) data_q[hit_way][idx][DATA_W*word_sel +: DATA_W] <= cpu_wdata;
        if (refill_done) begin
            data_q[victim_q][idx] <= mem_rline;
            tag_q[victim_q][idx]  <= tag;
        end
    end

endmodule
